// File: rtl/subleq_if.sv
// ============================================================================
//  Module      : subleq_if
//  Description : Bus between the SUBLEQ controller, pc_reg and the memory.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface subleq_if #(
    parameter int W = 8
);
    logic         RUN;
    logic [W-1:0] PC;
    logic [W-1:0] PCnew;
    logic         PC_WE;
    logic [W-1:0] MEM_ADDR;
    logic         MEM_RE;
    logic [W-1:0] MEM_RDATA;
    logic         MEM_WE;
    logic [W-1:0] MEM_WDATA;
    logic         HALTED;

    modport master (
        input  RUN, PC, MEM_RDATA,
        output PCnew, PC_WE, MEM_ADDR, MEM_RE, MEM_WE, MEM_WDATA, HALTED
    );

    modport slave (
        output RUN, PC, MEM_RDATA,
        input  PCnew, PC_WE, MEM_ADDR, MEM_RE, MEM_WE, MEM_WDATA, HALTED
    );
endinterface

`default_nettype wire

// File: rtl/subleq_ctrl.sv
// ============================================================================
//  Module      : subleq_ctrl
//  Description : Fetch/execute sequencer for the SUBLEQ one-instruction CPU.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module subleq_ctrl #(
    parameter int W         = 8,
    parameter int HALT_ADDR = 0
) (
    input  wire logic CLK,
    input  wire logic RST,
    subleq_if.master  bus
);

    localparam logic [W-1:0] HALT_PC = W'(HALT_ADDR);
    localparam logic [W-1:0] ONE     = W'(1);
    localparam logic [W-1:0] TWO     = W'(2);
    localparam logic [W-1:0] THREE   = W'(3);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_C    = 3'd2,
        S_RA   = 3'd3,
        S_RB   = 3'd4,
        S_EX   = 3'd5,
        S_WB   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    state_t       state;
    logic [W-1:0] op_a, op_b, op_c, val_a, val_b;
    logic [W-1:0] diff;
    logic         take_branch;
    logic         start;

    assign diff        = val_b - val_a;
    // Signed "<= 0" on the truncated result: sign bit set or all zeros.
    assign take_branch = diff[W-1] | (diff == '0);
    assign start       = (bus.PC != HALT_PC) && bus.RUN;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_A;
            op_a  <= '0;
            op_b  <= '0;
            op_c  <= '0;
            val_a <= '0;
            val_b <= '0;
        end else begin
            case (state)
                S_A: begin
                    if (bus.PC == HALT_PC) state <= S_HALT;
                    else if (bus.RUN)      state <= S_B;
                end
                S_B:  begin op_a  <= bus.MEM_RDATA; state <= S_C;  end
                S_C:  begin op_b  <= bus.MEM_RDATA; state <= S_RA; end
                S_RA: begin op_c  <= bus.MEM_RDATA; state <= S_RB; end
                S_RB: begin val_a <= bus.MEM_RDATA; state <= S_EX; end
                S_EX: begin val_b <= bus.MEM_RDATA; state <= S_WB; end
                S_WB:   state <= S_A;
                S_HALT: state <= S_HALT;
                default: state <= S_A;
            endcase
        end
    end

    // Reset gates the decode so nothing leaks out while RST is high,
    // including the cycle before the first reset edge.
    always_comb begin
        bus.PCnew     = '0;
        bus.PC_WE     = 1'b0;
        bus.MEM_ADDR  = '0;
        bus.MEM_RE    = 1'b0;
        bus.MEM_WE    = 1'b0;
        bus.MEM_WDATA = '0;
        bus.HALTED    = 1'b0;
        if (!RST) begin
            case (state)
                S_A: begin
                    if (start) begin
                        bus.MEM_ADDR = bus.PC;
                        bus.MEM_RE   = 1'b1;
                    end
                end
                S_B:  begin bus.MEM_ADDR = bus.PC + ONE; bus.MEM_RE = 1'b1; end
                S_C:  begin bus.MEM_ADDR = bus.PC + TWO; bus.MEM_RE = 1'b1; end
                S_RA: begin bus.MEM_ADDR = op_a;         bus.MEM_RE = 1'b1; end
                S_RB: begin bus.MEM_ADDR = op_b;         bus.MEM_RE = 1'b1; end
                S_WB: begin
                    bus.MEM_ADDR  = op_b;
                    bus.MEM_WDATA = diff;
                    bus.MEM_WE    = 1'b1;
                    bus.PC_WE     = 1'b1;
                    bus.PCnew     = take_branch ? op_c : (bus.PC + THREE);
                end
                S_HALT: bus.HALTED = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_subleq_ctrl.sv
// ============================================================================
//  Module      : tb_subleq_ctrl
//  Description : Bench for subleq_ctrl with memory and pc_reg models.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_subleq_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    subleq_if #(.W(8)) bus ();

    subleq_ctrl #(.W(8), .HALT_ADDR(0)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] pcnew;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [7:0] rd_addrs[$];
    logic [7:0] mem[256];
    logic [7:0] rdata;
    logic [7:0] pc;
    logic [7:0] pc_rst_val;
    logic       run;
    int         tests = 0;
    int         fails = 0;
    int         we_cnt = 0;
    int         pcwe_cnt = 0;
    int         we_snap, pcwe_snap;

    assign bus.RUN       = run;
    assign bus.PC        = pc;
    assign bus.MEM_RDATA = rdata;

    // pc_reg model
    always @(posedge clk) begin
        if (rst)            pc <= pc_rst_val;
        else if (bus.PC_WE) pc <= bus.PCnew;
    end

    // single-port memory model, one-cycle read latency
    always @(posedge clk) begin
        if (bus.MEM_RE) rdata <= mem[bus.MEM_ADDR];
        if (bus.MEM_WE) mem[bus.MEM_ADDR] = bus.MEM_WDATA;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Monitor: strobe sanity and scoreboard pop on each write-back.
    always @(negedge clk) begin
        if (!rst) begin
            chk("re_we_excl", 32'(bus.MEM_RE & bus.MEM_WE), 32'd0);
            if (bus.MEM_RE) rd_addrs.push_back(bus.MEM_ADDR);
            if (bus.MEM_WE) we_cnt++;
            if (bus.HALTED) chk("halt_quiet", 32'({bus.MEM_RE, bus.MEM_WE, bus.PC_WE}), 32'd0);
            if (bus.PC_WE) begin
                pcwe_cnt++;
                tests++;
                assert (sb.size() > 0) else begin
                    fails++;
                    $error("FAIL sb_empty: got write-back expected none");
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("wb_we",    32'(bus.MEM_WE),    32'd1);
                    chk("wb_addr",  32'(bus.MEM_ADDR),  32'(e.addr));
                    chk("wb_wdata", 32'(bus.MEM_WDATA), 32'(e.wdata));
                    chk("wb_pcnew", 32'(bus.PCnew),     32'(e.pcnew));
                end
            end
        end
    end

    task automatic wait_wb(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.PC_WE && k < 20);
        chk(tag, 32'(bus.PC_WE), 32'd1);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({bus.PCnew, bus.PC_WE, bus.MEM_ADDR, bus.MEM_RE,
                    bus.MEM_WE, bus.MEM_WDATA, bus.HALTED});
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[1] = 8'd10;  mem[2] = 8'd11;  mem[3] = 8'd7;
        mem[10] = 8'd3;  mem[11] = 8'd5;
        mem[4] = 8'd20;  mem[5] = 8'd21;  mem[6] = 8'd7;
        mem[20] = 8'd5;  mem[21] = 8'd5;
        mem[7] = 8'd22;  mem[8] = 8'd23;  mem[9] = 8'd30;
        mem[22] = 8'd1;  mem[23] = 8'h80;
        sb.push_back('{addr: 8'd11, wdata: 8'd2,   pcnew: 8'd4});
        sb.push_back('{addr: 8'd21, wdata: 8'd0,   pcnew: 8'd7});
        sb.push_back('{addr: 8'd23, wdata: 8'h7F,  pcnew: 8'd10});
        rdata = 8'h00;
        pc_rst_val = 8'd1;
        rst = 1'b1;
        run = 1'b1;

        // reset: all outputs low, then first fetch from PC=1
        @(posedge clk); #1;
        @(negedge clk); chk("rst_outs0", all_outs(), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("rst_outs1", all_outs(), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("first_re",   32'(bus.MEM_RE),   32'd1);
        chk("first_addr", 32'(bus.MEM_ADDR), 32'd1);
        repeat (5) @(posedge clk);
        @(negedge clk); chk("lat_not6", 32'(bus.PC_WE), 32'd0);
        @(posedge clk);
        @(negedge clk); chk("lat7", 32'(bus.PC_WE), 32'd1);

        // zero result branches; 0x80-0x01 is positive
        wait_wb("wb2");
        wait_wb("wb3");
        @(posedge clk); #1; run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk("run0_hold", 32'(bus.MEM_RE), 32'd0);
        end
        chk("pc_after3", 32'(pc), 32'd10);
        chk("mem23", 32'(mem[23]), 32'h7F);

        // wrap-around fetch from 254
        mem[254] = 8'd40; mem[255] = 8'd41; mem[0] = 8'd50;
        mem[40] = 8'd1;   mem[41] = 8'd9;
        sb.push_back('{addr: 8'd41, wdata: 8'd8, pcnew: 8'd1});
        pc_rst_val = 8'd254;
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; run = 1'b1; rd_addrs.delete();
        wait_wb("wb4");
        @(posedge clk); #1; run = 1'b0;
        chk("wrap_nrd", 32'(rd_addrs.size()), 32'd5);
        if (rd_addrs.size() >= 5) begin
            chk("wrap_rd0", 32'(rd_addrs[0]), 32'd254);
            chk("wrap_rd1", 32'(rd_addrs[1]), 32'd255);
            chk("wrap_rd2", 32'(rd_addrs[2]), 32'd0);
            chk("wrap_rd3", 32'(rd_addrs[3]), 32'd40);
            chk("wrap_rd4", 32'(rd_addrs[4]), 32'd41);
        end
        chk("wrap_pc", 32'(pc), 32'd1);

        // halt at PC=0
        pc_rst_val = 8'd0;
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; run = 1'b1;
        @(negedge clk);
        chk("halt_sa_re", 32'(bus.MEM_RE), 32'd0);
        chk("halt_sa_h",  32'(bus.HALTED), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); chk("halted", 32'(bus.HALTED), 32'd1);
        end
        pc_rst_val = 8'd1;
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk); chk("halt_rst", 32'(bus.HALTED), 32'd0);

        // abort in S_RB, then RUN=0 hold, then restart
        @(posedge clk); #1; rst = 1'b0; run = 1'b1;
        we_snap = we_cnt; pcwe_snap = pcwe_cnt;
        repeat (4) @(posedge clk);
        @(negedge clk); chk("srb_addr", 32'(bus.MEM_ADDR), 32'd11);
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_hold_re", 32'(bus.MEM_RE), 32'd0);
        end
        chk("abort_no_we",   32'(we_cnt),   32'(we_snap));
        chk("abort_no_pcwe", 32'(pcwe_cnt), 32'(pcwe_snap));
        // mem[11] holds 2 from the first instruction: 2-3 = -1 branches to 7
        sb.push_back('{addr: 8'd11, wdata: 8'hFF, pcnew: 8'd7});
        @(posedge clk); #1; run = 1'b1;
        @(negedge clk);
        chk("restart_re",   32'(bus.MEM_RE),   32'd1);
        chk("restart_addr", 32'(bus.MEM_ADDR), 32'd1);
        wait_wb("wb6");
        @(posedge clk); #1; run = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
